// File: rtl/bit_ram_pkg.sv
// Shared constants and types for the bit-serial read RAM (bit_ram_w32r1).
// Holds the word/bit-select widths and the CA-code and nav-message presets.
package bit_ram_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BIT_SEL_W = 5;

  // CA spreading-code store: 32 words = 1024 chips (1023 used)
  localparam int unsigned CA_WR_AW    = 5;
  localparam int unsigned CA_DEPTH    = 32;
  localparam int unsigned CA_CODE_LEN = 1023;

  // Navigation-message store: 47 words, 1500 bits used
  localparam int unsigned MSG_WR_AW = 6;
  localparam int unsigned MSG_DEPTH = 47;
  localparam int unsigned MSG_LEN   = 1500;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/bit_ram_w32r1_word_bit_mux.sv
// word_bit_mux: combinational bit selector for bit_ram_w32r1.
// Splits a bit address into word/bit indices, range-checks the word index
// against DEPTH and returns the addressed bit, or 0 for unimplemented words.
module word_bit_mux
  import bit_ram_pkg::*;
#(
  parameter int unsigned WR_AW = 5,
  parameter int unsigned DEPTH = 32
) (
  input  word_t                        mem [DEPTH],
  input  logic [WR_AW+BIT_SEL_W-1:0]   rd_addr,
  output logic                         bit_o
);

  logic [WR_AW-1:0]     word_idx;
  logic [BIT_SEL_W-1:0] bit_idx;
  word_t                sel_word;
  logic                 in_range;

  // Select the addressed word by matching only implemented indices, so an
  // index at or above DEPTH falls through to the zero default.
  always_comb begin
    word_idx = rd_addr[WR_AW+BIT_SEL_W-1:BIT_SEL_W];
    bit_idx  = rd_addr[BIT_SEL_W-1:0];
    sel_word = '0;
    in_range = 1'b0;
    for (int unsigned w = 0; w < DEPTH; w++) begin
      if (word_idx == WR_AW'(w)) begin
        sel_word = mem[w];
        in_range = 1'b1;
      end
    end
    bit_o = in_range & sel_word[bit_idx];
  end

endmodule

// File: rtl/bit_ram_w32r1.sv
// bit_ram_w32r1: single-clock flop RAM with 32-bit word writes and 1-bit
// registered reads (LSB first within each word). Writes to words >= DEPTH
// are dropped; reads from words >= DEPTH return 0. Same-edge read of a word
// being written returns the old bit.
// Optional: define RAM_OUT_REG_EN to add a second output register (2-cycle
// read latency, also cleared by rst_n).
module bit_ram_w32r1
  import bit_ram_pkg::*;
#(
  parameter int unsigned WR_AW = 5,
  parameter int unsigned DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    data,
  input  logic [WR_AW-1:0]     wraddress,
  input  logic                 wren,
  input  logic [WR_AW+4:0]     rdaddress,
  output logic                 q
);

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];
  logic  rd_bit;
  logic  q_d;
  logic  q_q;

  // Next storage state: only implemented word indices can match, which
  // silently drops writes addressed at or above DEPTH.
  always_comb begin
    for (int unsigned w = 0; w < DEPTH; w++) begin
      mem_d[w] = mem_q[w];
      if (wren && (wraddress == WR_AW'(w))) begin
        mem_d[w] = data;
      end
    end
  end

  // Storage array, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < DEPTH; w++) begin
        mem_q[w] <= mem_d[w];
      end
    end
  end

  // Read path taps the pre-edge storage, giving read-before-write.
  word_bit_mux #(
    .WR_AW (WR_AW),
    .DEPTH (DEPTH)
  ) u_word_bit_mux (
    .mem     (mem_q),
    .rd_addr (rdaddress),
    .bit_o   (rd_bit)
  );

  // Output bit selected for the address sampled at this edge.
  always_comb begin
    q_d = rd_bit;
  end

  // First read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic q_pipe_d;
  logic q_pipe_q;

  // Extra output stage feeding straight from the first read register.
  always_comb begin
    q_pipe_d = q_q;
  end

  // Second read register for the 2-cycle latency build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_pipe_q <= 1'b0;
    end else begin
      q_pipe_q <= q_pipe_d;
    end
  end

  assign q = q_pipe_q;
`else
  assign q = q_q;
`endif

endmodule

// File: tb/tb_bit_ram_w32r1.sv
// Self-checking bench for bit_ram_w32r1: CA-preset and MSG-preset instances
// compared against an array-based model of the word store.
`timescale 1ns/1ps
module tb_bit_ram_w32r1;
  import bit_ram_pkg::*;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] ca_data, msg_data;
  logic [4:0]  ca_wa;
  logic [5:0]  msg_wa;
  logic        ca_we, msg_we;
  logic [9:0]  ca_ra;
  logic [10:0] msg_ra;
  logic        ca_q, msg_q;

  bit_ram_w32r1 #(.WR_AW(CA_WR_AW), .DEPTH(CA_DEPTH)) u_ca (
    .clk(clk), .rst_n(rst_n), .data(ca_data), .wraddress(ca_wa),
    .wren(ca_we), .rdaddress(ca_ra), .q(ca_q)
  );

  bit_ram_w32r1 #(.WR_AW(MSG_WR_AW), .DEPTH(MSG_DEPTH)) u_msg (
    .clk(clk), .rst_n(rst_n), .data(msg_data), .wraddress(msg_wa),
    .wren(msg_we), .rdaddress(msg_ra), .q(msg_q)
  );

  // Reference: plain word arrays plus a queue of expected bits per DUT
  logic [31:0] ca_mem  [32];
  logic [31:0] msg_mem [64];
  logic        ca_exp_q[$];
  logic        msg_exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic ref_bit(input bit msg, input int unsigned addr);
    int unsigned w     = addr / 32;
    int unsigned b     = addr % 32;
    int unsigned depth = msg ? MSG_DEPTH : CA_DEPTH;
    if (w >= depth) return 1'b0;
    return msg ? msg_mem[w][b] : ca_mem[w][b];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ca_mem[i] = '0;
    for (int i = 0; i < 64; i++) msg_mem[i] = '0;
    ca_exp_q.delete();
    msg_exp_q.delete();
  endtask

  // One clock: record expected read (old contents), clock, apply writes,
  // and hand back the bit now due at each q together with its expectation.
  task automatic tick(output logic gc, output logic ec, output bit vc,
                      output logic gm, output logic em, output bit vm);
    vc = 0; vm = 0; gc = 0; ec = 0; gm = 0; em = 0;
    if (rst_n) begin
      ca_exp_q.push_back(ref_bit(1'b0, ca_ra));
      msg_exp_q.push_back(ref_bit(1'b1, msg_ra));
    end
    @(posedge clk); #1;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (ca_we && ca_wa < CA_DEPTH)    ca_mem[ca_wa]   = ca_data;
    if (msg_we && msg_wa < MSG_DEPTH) msg_mem[msg_wa] = msg_data;
    if (ca_exp_q.size() >= LAT)  begin ec = ca_exp_q.pop_front();  gc = ca_q;  vc = 1; end
    if (msg_exp_q.size() >= LAT) begin em = msg_exp_q.pop_front(); gm = msg_q; vm = 1; end
  endtask

  task automatic test_reset();
    logic gc, ec, gm, em; bit vc, vm;
    rst_n = 0;
    ca_we = 1; ca_wa = 0; ca_data = '1; ca_ra = 0;
    msg_we = 1; msg_wa = 0; msg_data = '1; msg_ra = 0;
    repeat (2) tick(gc, ec, vc, gm, em, vm);
    n_tests++;
    if (ca_q !== 1'b0) begin n_fail++; $display("FAIL reset_q_ca got=%b exp=0", ca_q); end
    n_tests++;
    if (msg_q !== 1'b0) begin n_fail++; $display("FAIL reset_q_msg got=%b exp=0", msg_q); end
    ca_we = 0; msg_we = 0;
    rst_n = 1;
    for (int i = 0; i < 32 + LAT - 1; i++) begin
      if (i < 32) begin ca_ra = 10'(i); msg_ra = 11'(i); end
      tick(gc, ec, vc, gm, em, vm);
      if (vc) begin n_tests++; if (gc !== 1'b0) begin n_fail++; $display("FAIL reset_clear_ca got=%b exp=0", gc); end end
      if (vm) begin n_tests++; if (gm !== 1'b0) begin n_fail++; $display("FAIL reset_clear_msg got=%b exp=0", gm); end end
    end
  endtask

  task automatic test_bit_order();
    logic gc, ec, gm, em; bit vc, vm;
    logic [5:0] want;
    want = 6'b100001;  // addresses 37..32
    ca_we = 1; ca_wa = 1; ca_data = 32'h0000_0021;
    tick(gc, ec, vc, gm, em, vm);
    ca_we = 0;
    for (int i = 0; i < 6; i++) begin
      ca_ra = 10'(32 + i);
      repeat (LAT) begin
        tick(gc, ec, vc, gm, em, vm);
        if (vc) begin n_tests++; if (gc !== ec) begin n_fail++; $display("FAIL bit_order_model got=%b exp=%b", gc, ec); end end
      end
      n_tests++;
      if (ca_q !== want[i]) begin n_fail++; $display("FAIL bit_order addr=%0d got=%b exp=%b", 32 + i, ca_q, want[i]); end
    end
  endtask

  task automatic test_ca_sweep();
    logic gc, ec, gm, em; bit vc, vm;
    ca_we = 1;
    for (int w = 0; w < 32; w++) begin
      ca_wa = 5'(w); ca_data = $urandom;
      if (w == 31) ca_data[31] = ~ca_data[30];  // bit 1023 differs from its neighbour
      tick(gc, ec, vc, gm, em, vm);
    end
    ca_we = 0;
    for (int a = 0; a < 1024 + LAT - 1; a++) begin
      if (a < 1024) ca_ra = 10'(a);
      tick(gc, ec, vc, gm, em, vm);
      if (vc) begin n_tests++; if (gc !== ec) begin n_fail++; $display("FAIL ca_sweep addr=%0d got=%b exp=%b", a - (LAT - 1), gc, ec); end end
    end
    n_tests++;
    if (ca_q !== ca_mem[31][31]) begin n_fail++; $display("FAIL ca_bit1023 got=%b exp=%b", ca_q, ca_mem[31][31]); end
  endtask

  task automatic test_msg_bounds();
    logic gc, ec, gm, em; bit vc, vm;
    logic [10:0] oor [2];
    oor[0] = 11'd1504; oor[1] = 11'd2047;
    msg_we = 1; msg_wa = 6'd47; msg_data = '1;
    tick(gc, ec, vc, gm, em, vm);
    msg_wa = 6'd63;
    tick(gc, ec, vc, gm, em, vm);
    msg_wa = 6'd46; msg_data = $urandom;
    tick(gc, ec, vc, gm, em, vm);
    msg_we = 0;
    for (int a = 1472; a < 1504 + LAT - 1; a++) begin
      if (a < 1504) msg_ra = 11'(a);
      tick(gc, ec, vc, gm, em, vm);
      if (vm) begin n_tests++; if (gm !== em) begin n_fail++; $display("FAIL msg_word46 got=%b exp=%b", gm, em); end end
    end
    for (int k = 0; k < 2; k++) begin
      msg_ra = oor[k];
      repeat (LAT) tick(gc, ec, vc, gm, em, vm);
      n_tests++;
      if (msg_q !== 1'b0) begin n_fail++; $display("FAIL msg_oor addr=%0d got=%b exp=0", oor[k], msg_q); end
    end
  endtask

  task automatic test_rdw();
    logic gc, ec, gm, em; bit vc, vm;
    ca_we = 1; ca_wa = 3; ca_data = '0; ca_ra = 0;
    tick(gc, ec, vc, gm, em, vm);
    ca_data = '1; ca_ra = 10'd96;
    tick(gc, ec, vc, gm, em, vm);
    ca_we = 0;
    repeat (LAT - 1) tick(gc, ec, vc, gm, em, vm);
    n_tests++;
    if (ca_q !== 1'b0) begin n_fail++; $display("FAIL rdw_old got=%b exp=0", ca_q); end
    tick(gc, ec, vc, gm, em, vm);
    n_tests++;
    if (ca_q !== 1'b1) begin n_fail++; $display("FAIL rdw_new got=%b exp=1", ca_q); end
  endtask

  task automatic test_async_reset();
    logic gc, ec, gm, em; bit vc, vm;
    ca_we = 1; ca_wa = 0; ca_data = '1; ca_ra = 0;
    msg_we = 1; msg_wa = 0; msg_data = '1; msg_ra = 0;
    tick(gc, ec, vc, gm, em, vm);
    ca_we = 0; msg_we = 0;
    repeat (LAT) tick(gc, ec, vc, gm, em, vm);
    n_tests++;
    if (ca_q !== 1'b1) begin n_fail++; $display("FAIL async_pre_q got=%b exp=1", ca_q); end
    #2 rst_n = 0;
    #1;
    n_tests++;
    if (ca_q !== 1'b0) begin n_fail++; $display("FAIL async_q_ca got=%b exp=0", ca_q); end
    n_tests++;
    if (msg_q !== 1'b0) begin n_fail++; $display("FAIL async_q_msg got=%b exp=0", msg_q); end
    tick(gc, ec, vc, gm, em, vm);
    rst_n = 1;
    for (int i = 0; i < 32 + LAT - 1; i++) begin
      if (i < 32) begin ca_ra = 10'(i); msg_ra = 11'(i); end
      tick(gc, ec, vc, gm, em, vm);
      if (vc) begin n_tests++; if (gc !== 1'b0) begin n_fail++; $display("FAIL async_clear_ca got=%b exp=0", gc); end end
      if (vm) begin n_tests++; if (gm !== 1'b0) begin n_fail++; $display("FAIL async_clear_msg got=%b exp=0", gm); end end
    end
  endtask

  task automatic test_random();
    logic gc, ec, gm, em; bit vc, vm;
    for (int i = 0; i < 400; i++) begin
      ca_we  = ($urandom_range(0, 2) == 0);
      ca_wa  = 5'($urandom_range(0, 31));
      ca_data = $urandom;
      ca_ra  = 10'($urandom_range(0, 1023));
      msg_we = ($urandom_range(0, 2) == 0);
      msg_wa = 6'($urandom_range(0, 63));
      msg_data = $urandom;
      msg_ra = 11'($urandom_range(0, 2047));
      tick(gc, ec, vc, gm, em, vm);
      if (vc) begin n_tests++; if (gc !== ec) begin n_fail++; $display("FAIL random_ca cycle=%0d got=%b exp=%b", i, gc, ec); end end
      if (vm) begin n_tests++; if (gm !== em) begin n_fail++; $display("FAIL random_msg cycle=%0d got=%b exp=%b", i, gm, em); end end
    end
    ca_we = 0; msg_we = 0;
  endtask

  initial begin
    rst_n = 0;
    ca_we = 0; ca_wa = 0; ca_data = 0; ca_ra = 0;
    msg_we = 0; msg_wa = 0; msg_data = 0; msg_ra = 0;
    model_clear();
    #12;
    test_reset();
    test_bit_order();
    test_ca_sweep();
    test_msg_bounds();
    test_rdw();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
